// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apu_pkg
// Purpose  : Shared APU constants: register offsets, widths, length table.
// Revision : 1.0
// ============================================================================
package apu_pkg;

    localparam int TRI_TIMER_W = 11;
    localparam int TRI_LIN_W   = 7;
    localparam int APU_LEN_W   = 8;

    localparam logic [1:0] TRI_CTRL = 2'd0;
    localparam logic [1:0] TRI_LO   = 2'd2;
    localparam logic [1:0] TRI_HI   = 2'd3;

    // Indexed by the 5-bit length index written to the channel's high register
    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

endpackage
`default_nettype wire

// File: rtl/apu_triangle_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : apu_triangle_timer_if
// Purpose  : CPU register bus, frame ticks and status outputs of the triangle timer.
// Revision : 1.0
// ============================================================================
interface apu_triangle_timer_if;
    logic       reg_wr;
    logic [1:0] reg_addr;
    logic [7:0] reg_data;
    logic       chan_en;
    logic       quarter_tick;
    logic       half_tick;
    logic       seq_clk;
    logic       len_active;
    logic       lin_active;

    modport master (
        output reg_wr, reg_addr, reg_data, chan_en, quarter_tick, half_tick,
        input  seq_clk, len_active, lin_active
    );

    modport slave (
        input  reg_wr, reg_addr, reg_data, chan_en, quarter_tick, half_tick,
        output seq_clk, len_active, lin_active
    );
endinterface
`default_nettype wire

// File: rtl/apu_length_counter.sv
`default_nettype none
// ============================================================================
// Module   : apu_length_counter
// Purpose  : Channel length counter with load, halt, enable and half-frame decrement.
// Revision : 1.0
// ============================================================================
module apu_length_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             halt,
    input  logic             tick,
    output logic             active
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    // Disable dominates; a load on a tick cycle suppresses that tick's decrement
    always_comb begin
        count_d = count_q;
        if (!en) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (tick && !halt && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active = (count_q != '0);

endmodule
`default_nettype wire

// File: rtl/apu_triangle_timer.sv
`default_nettype none
// ============================================================================
// Module   : apu_triangle_timer
// Purpose  : Triangle channel registers, period timer and linear/length gating of seq_clk.
// Revision : 1.0
// ============================================================================
module apu_triangle_timer
    import apu_pkg::*;
#(
    parameter int TIMER_W = TRI_TIMER_W,
    parameter int LIN_W   = TRI_LIN_W,
    parameter int LEN_W   = APU_LEN_W
) (
    input  logic                 cpu_clk,
    input  logic                 reset,
    apu_triangle_timer_if.slave  bus
);

    logic               ctrl_q,        ctrl_d;
    logic [LIN_W-1:0]   lin_reload_q,  lin_reload_d;
    logic [TIMER_W-1:0] period_q,      period_d;
    logic [TIMER_W-1:0] timer_q,       timer_d;
    logic [LIN_W-1:0]   linear_q,      linear_d;
    logic               reload_flag_q, reload_flag_d;
    logic               seq_clk_q,     seq_clk_d;

    logic wr_ctrl, wr_lo, wr_hi;
    logic len_active;

    assign wr_ctrl = bus.reg_wr && (bus.reg_addr == TRI_CTRL);
    assign wr_lo   = bus.reg_wr && (bus.reg_addr == TRI_LO);
    assign wr_hi   = bus.reg_wr && (bus.reg_addr == TRI_HI);

    always_comb begin
        ctrl_d        = ctrl_q;
        lin_reload_d  = lin_reload_q;
        period_d      = period_q;
        timer_d       = timer_q;
        linear_d      = linear_q;
        reload_flag_d = reload_flag_q;
        seq_clk_d     = seq_clk_q;

        if (wr_ctrl) begin
            ctrl_d       = bus.reg_data[7];
            lin_reload_d = bus.reg_data[LIN_W-1:0];
        end
        if (wr_lo) begin
            period_d[7:0] = bus.reg_data;
        end
        if (wr_hi) begin
            period_d[TIMER_W-1:8] = bus.reg_data[TIMER_W-9:0];
        end

        // Reload uses the pre-write period; periods 0/1 are ultrasonic and stay muted
        if (timer_q == '0) begin
            timer_d = period_q;
            if (len_active && (linear_q != '0) && (period_q >= TIMER_W'(2))) begin
                seq_clk_d = ~seq_clk_q;
            end
        end else begin
            timer_d = timer_q - 1'b1;
        end

        if (bus.quarter_tick) begin
            if (reload_flag_q) begin
                linear_d = lin_reload_q;
            end else if (linear_q != '0) begin
                linear_d = linear_q - 1'b1;
            end
            if (!ctrl_q) begin
                reload_flag_d = 1'b0;
            end
        end
        // A high-register write re-arms the reload even on a tick cycle
        if (wr_hi) begin
            reload_flag_d = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            ctrl_q        <= 1'b0;
            lin_reload_q  <= '0;
            period_q      <= '0;
            timer_q       <= '0;
            linear_q      <= '0;
            reload_flag_q <= 1'b0;
            seq_clk_q     <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            lin_reload_q  <= lin_reload_d;
            period_q      <= period_d;
            timer_q       <= timer_d;
            linear_q      <= linear_d;
            reload_flag_q <= reload_flag_d;
            seq_clk_q     <= seq_clk_d;
        end
    end

    apu_length_counter #(
        .LEN_W (LEN_W)
    ) u_length (
        .clk      (cpu_clk),
        .rst_n    (reset),
        .en       (bus.chan_en),
        .load     (wr_hi),
        .load_val (LEN_W'(LENGTH_TABLE[bus.reg_data[7:3]])),
        .halt     (ctrl_q),
        .tick     (bus.half_tick),
        .active   (len_active)
    );

    assign bus.seq_clk    = seq_clk_q;
    assign bus.len_active = len_active;
    assign bus.lin_active = (linear_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_apu_triangle_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apu_triangle_timer
// Purpose  : Self-checking bench for apu_triangle_timer against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_apu_triangle_timer;

    logic cpu_clk = 1'b0;
    logic reset   = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    apu_triangle_timer_if bus ();

    apu_triangle_timer dut (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .bus     (bus)
    );

    localparam int LT [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                               12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

    int checks = 0;
    int errors = 0;
    int tog    = 0;
    logic prev_seq = 1'b0;
    bit run = 1'b0;

    // Behavioural model: integer state, "expiry" countdown, table lookup
    int m_period, m_timer, m_lin, m_len, m_ctrl, m_linrl, m_rflag;
    bit m_seq;

    always @(posedge cpu_clk or negedge reset) begin : model
        int n_timer, n_lin, n_len, n_rflag;
        if (!reset) begin
            m_period = 0; m_timer = 0; m_lin = 0; m_len = 0;
            m_ctrl = 0; m_linrl = 0; m_rflag = 0; m_seq = 1'b0;
        end else begin
            if (m_timer == 0) begin
                n_timer = m_period;
                if (m_len > 0 && m_lin > 0 && m_period > 1) m_seq = ~m_seq;
            end else begin
                n_timer = m_timer - 1;
            end
            n_lin   = m_lin;
            n_rflag = m_rflag;
            if (bus.quarter_tick) begin
                n_lin = m_rflag ? m_linrl : (m_lin > 0 ? m_lin - 1 : 0);
                if (m_ctrl == 0) n_rflag = 0;
            end
            n_len = m_len;
            if (!bus.chan_en) n_len = 0;
            else if (bus.reg_wr && bus.reg_addr == 2'd3) n_len = LT[bus.reg_data >> 3];
            else if (bus.half_tick && m_ctrl == 0 && m_len > 0) n_len = m_len - 1;
            if (bus.reg_wr) begin
                case (bus.reg_addr)
                    2'd0: begin m_ctrl = bus.reg_data / 128; m_linrl = bus.reg_data % 128; end
                    2'd2: m_period = (m_period / 256) * 256 + bus.reg_data;
                    2'd3: begin m_period = (bus.reg_data % 8) * 256 + m_period % 256; n_rflag = 1; end
                    default: ;
                endcase
            end
            m_timer = n_timer; m_lin = n_lin; m_len = n_len; m_rflag = n_rflag;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge cpu_clk) begin
        if (run) begin
            check("seq_clk",    int'(bus.seq_clk),    int'(m_seq));
            check("len_active", int'(bus.len_active), int'(m_len != 0));
            check("lin_active", int'(bus.lin_active), int'(m_lin != 0));
        end
        if (bus.seq_clk !== prev_seq) tog++;
        prev_seq = bus.seq_clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge cpu_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_data = d;
        step(1);
        bus.reg_wr = 1'b0;
    endtask

    task automatic qtick();
        bus.quarter_tick = 1'b1; step(1); bus.quarter_tick = 1'b0;
    endtask

    task automatic htick();
        bus.half_tick = 1'b1; step(1); bus.half_tick = 1'b0;
    endtask

    int t0;

    initial begin
        bus.reg_wr = 1'b0; bus.reg_addr = 2'd0; bus.reg_data = 8'd0;
        bus.chan_en = 1'b0; bus.quarter_tick = 1'b0; bus.half_tick = 1'b0;
        step(3);
        check("reset_seq", int'(bus.seq_clk), 0);
        check("reset_len", int'(bus.len_active), 0);
        check("reset_lin", int'(bus.lin_active), 0);
        reset = 1'b1;
        run = 1'b1;
        step(1);

        // Basic toggling at period 3
        bus.chan_en = 1'b1;
        wr(2'd0, 8'h7F); wr(2'd2, 8'h03); wr(2'd3, 8'h08);
        qtick();
        check("t1_lin", int'(bus.lin_active), 1);
        check("t1_len", int'(bus.len_active), 1);
        step(3); t0 = tog; step(32);
        check("t1_toggles32", tog - t0, 8);

        // Ultrasonic mute
        wr(2'd2, 8'h01);
        step(4); t0 = tog; step(100);
        check("t2_period1_toggles", tog - t0, 0);

        // Linear counter countdown with ctrl=0
        wr(2'd2, 8'h03); wr(2'd0, 8'h02); wr(2'd3, 8'h08);
        qtick(); check("t3_lin_after1", int'(bus.lin_active), 1);
        qtick(); check("t3_lin_after2", int'(bus.lin_active), 1);
        t0 = tog; step(8);
        check("t3_toggles_lin1", tog - t0, 2);
        qtick(); check("t3_lin_after3", int'(bus.lin_active), 0);
        t0 = tog; step(20);
        check("t3_toggles_lin0", tog - t0, 0);

        // Length idx0 = 10, halt off
        wr(2'd3, 8'h00);
        repeat (9) htick();
        check("t4_len_after9", int'(bus.len_active), 1);
        htick(); check("t4_len_after10", int'(bus.len_active), 0);
        htick(); check("t4_len_after11", int'(bus.len_active), 0);

        // Channel disable
        wr(2'd3, 8'h08);
        check("t5_len_loaded", int'(bus.len_active), 1);
        bus.chan_en = 1'b0; step(1);
        check("t5_len_disabled", int'(bus.len_active), 0);
        wr(2'd3, 8'h08); step(1);
        check("t5_len_wr_disabled", int'(bus.len_active), 0);
        bus.chan_en = 1'b1; step(2);
        check("t5_len_reenabled", int'(bus.len_active), 0);

        // Load with simultaneous half_tick: full 10, no decrement
        bus.reg_wr = 1'b1; bus.reg_addr = 2'd3; bus.reg_data = 8'h00; bus.half_tick = 1'b1;
        step(1);
        bus.reg_wr = 1'b0; bus.half_tick = 1'b0;
        repeat (9) htick();
        check("t6_len_after9", int'(bus.len_active), 1);
        htick(); check("t6_len_after10", int'(bus.len_active), 0);

        // Asynchronous reset mid-toggle
        wr(2'd0, 8'h7F); wr(2'd2, 8'h03); wr(2'd3, 8'h08);
        qtick(); step(6);
        reset = 1'b0; #2;
        check("t7_rst_seq", int'(bus.seq_clk), 0);
        check("t7_rst_len", int'(bus.len_active), 0);
        check("t7_rst_lin", int'(bus.lin_active), 0);
        step(2);
        reset = 1'b1;
        step(1);
        check("t7_rel_seq", int'(bus.seq_clk), 0);
        wr(2'd0, 8'h7F); wr(2'd2, 8'h03); wr(2'd3, 8'h08);
        qtick(); step(3); t0 = tog; step(20);
        check("t7_toggles20", tog - t0, 5);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
